tt_checker: RTL

TT_CHECKER -- requirements
Module: tt_checker

---
 rtl/tt_checker.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tt_checker.sv
// Truth-table checker: sweeps every input vector into a DUT and counts responses that differ from GOLDEN.
// Optional first-failure capture is compiled in with `define TT_CHECKER_FIRST_FAIL_EN.
module tt_checker #(
    parameter int                   N_IN   = 2,
    parameter logic [2**N_IN-1:0]   GOLDEN = 4'b1010,
    parameter int                   SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   err_cnt,
    output logic            pass
`ifdef TT_CHECKER_FIRST_FAIL_EN
    ,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld
`endif
);

    // state | meaning
    // IDLE  | waiting for start; results of the last sweep held
    // RUN   | driving vectors, sampling dut_out in the last settle cycle
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LD = SW'(SETTLE - 1);
    localparam logic [N_IN:0]   ERR_MAX   = {1'b1, {N_IN{1'b0}}};

    state_t            state_q;
    logic [N_IN-1:0]   vec_q;
    logic [SW-1:0]     settle_q;
    logic [N_IN:0]     err_q;
    logic [N_IN:0]     err_d;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              mismatch;
    logic              last_vec;

    assign mismatch = (dut_out != GOLDEN[vec_q]);
    assign last_vec = &vec_q;
    assign err_d    = (mismatch && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;

`ifdef TT_CHECKER_FIRST_FAIL_EN
    logic [N_IN-1:0]   ff_q;
    logic              ffv_q;

    // Vectors are visited in ascending order, so the first capture is the lowest index.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q  <= '0;
            ffv_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            ffv_q <= 1'b0;
        end else if (state_q == S_RUN && settle_q == '0 && mismatch && !ffv_q) begin
            ff_q  <= vec_q;
            ffv_q <= 1'b1;
        end
    end

    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_RUN;
                        vec_q    <= '0;
                        settle_q <= SETTLE_LD;
                        err_q    <= '0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (settle_q == '0) begin
                        err_q <= err_d;
                        if (last_vec) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            vec_q    <= vec_q + 1'b1;
                            settle_q <= SETTLE_LD;
                        end
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in  = vec_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = err_q;
    assign pass    = pass_q;

endmodule
